mac_accumulator: RTL



---
 rtl/mac_accumulator.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// Saturating multiply-accumulate back end.
// Products from the array multiplier are summed into an unsigned saturating
// accumulator. Products are grouped into frames that close on p_last or on
// the term limit. Each finished frame sum is held on acc with a valid/ready
// handshake until the downstream consumer takes it.
module mac_accumulator #(
  parameter int W         = 4,
  parameter int ACC_W     = 12,
  parameter int MAX_TERMS = 16,
  parameter int CNT_W     = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               p_valid,
  output logic               p_ready,
  input  logic [2*W-1:0]     p,
  input  logic               p_last,
  output logic [ACC_W-1:0]   acc,
  output logic               acc_valid,
  input  logic               acc_ready,
  output logic [CNT_W-1:0]   count,
  output logic               ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MaxCount = CNT_W'(MAX_TERMS);
  localparam logic [CNT_W-1:0] OneCount = CNT_W'(1);
  localparam logic [ACC_W-1:0] AccMax   = '1;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;

  logic [ACC_W-1:0]   pExt;
  logic [ACC_W:0]     sumWide;
  logic [CNT_W-1:0]   countInc;
  logic               accept;

  // Ready is a pure decode of state, forced low while reset is held.
  always_comb begin
    p_ready = rst_n && (state_q != DONE);
  end

  // Datapath helpers: zero-extended product, carry-out sum, next count.
  always_comb begin
    pExt     = ACC_W'(p);
    sumWide  = {1'b0, acc_q} + {1'b0, pExt};
    countInc = count_q + OneCount;
    accept   = p_valid && p_ready;
  end

  // Next-state logic: clear wins over everything, then accept or handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;

    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = pExt;
            count_d = OneCount;
            ovf_d   = 1'b0;
            if (p_last || (OneCount == MaxCount)) begin
              state_d = DONE;
              valid_d = 1'b1;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (sumWide[ACC_W]) begin
              acc_d = AccMax;
              ovf_d = 1'b1;
            end else begin
              acc_d = sumWide[ACC_W-1:0];
            end
            count_d = countInc;
            if (p_last || (countInc == MaxCount)) begin
              state_d = DONE;
              valid_d = 1'b1;
            end
          end
        end
        DONE: begin
          if (acc_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Every output other than p_ready comes straight from a register.
  always_comb begin
    acc       = acc_q;
    count     = count_q;
    ovf       = ovf_q;
    acc_valid = valid_q;
  end

endmodule
